// File: rtl/log_mem_ctrl_pkg.sv
// Shared constants for the logging memory controller: FSM state encodings
// and the default log-RAM address width.
package log_mem_ctrl_pkg;

  // Debug-visible state encoding; o_state exposes these values directly.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2,
    READ  = 2'd3
  } state_e;

  // Default log-RAM address width (depth = 2**NB_ADDR).
  localparam int NB_ADDR_DEFAULT = 8;

endpackage : log_mem_ctrl_pkg

// File: rtl/log_mem_ctrl.sv
// Logging memory controller. Sequences one write pass that fills both log
// BRAMs with datapath samples, holds the log until read-out is requested,
// then streams the whole log back in address order. One address counter is
// shared by the write and read phases; the FSM and counter live together.
module log_mem_ctrl
  import log_mem_ctrl_pkg::*;
#(
  parameter int NB_ADDR = NB_ADDR_DEFAULT
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_log_en,
  input  logic               i_read_en,
  input  logic               i_sample_valid,
  output logic               o_ram_we,
  output logic [NB_ADDR-1:0] o_ram_addr,
  output logic               o_rd_valid,
  output logic               o_full,
  output logic [1:0]         o_state
);

  localparam logic [NB_ADDR-1:0] ADDR_ZERO = {NB_ADDR{1'b0}};
  localparam logic [NB_ADDR-1:0] ADDR_ONE  = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_ADDR-1:0] ADDR_LAST = {NB_ADDR{1'b1}};

  state_e             state_r;
  state_e             state_s;
  logic [NB_ADDR-1:0] addr_r;
  logic [NB_ADDR-1:0] addr_s;
  logic               full_r;
  logic               full_s;
  logic               rd_valid_r;
  logic               rd_valid_s;
  logic               we_s;

  // State, address counter, full flag and read-valid pipeline register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r    <= IDLE;
      addr_r     <= ADDR_ZERO;
      full_r     <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      full_r     <= full_s;
      rd_valid_r <= rd_valid_s;
    end
  end

  // Next-state, next-address and write-strobe decode.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    full_s     = full_r;
    rd_valid_s = 1'b0;
    we_s       = 1'b0;
    case (state_r)
      IDLE: begin
        // Read requests are meaningless without a completed log.
        full_s = 1'b0;
        addr_s = ADDR_ZERO;
        if (i_log_en) begin
          state_s = WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        // Strobe passes straight through so no sample is delayed or lost.
        we_s = i_sample_valid;
        if (i_sample_valid) begin
          if (addr_r == ADDR_LAST) begin
            // Last slot written: the log is complete even if logging stops now.
            state_s = FULL;
            addr_s  = ADDR_ZERO;
            full_s  = 1'b1;
          end else if (!i_log_en) begin
            // Final write still lands, then the partial log is discarded.
            state_s = IDLE;
            addr_s  = ADDR_ZERO;
          end else begin
            addr_s = addr_r + ADDR_ONE;
          end
        end else if (!i_log_en) begin
          state_s = IDLE;
          addr_s  = ADDR_ZERO;
        end else begin
          state_s = WRITE;
        end
      end
      FULL: begin
        // Log is frozen; logging inputs are ignored so nothing is overwritten.
        full_s = 1'b1;
        if (i_read_en) begin
          state_s = READ;
          addr_s  = ADDR_ZERO;
        end else begin
          state_s = FULL;
        end
      end
      READ: begin
        // Data for this cycle's address appears one cycle later.
        rd_valid_s = i_read_en;
        if (i_read_en) begin
          if (addr_r == ADDR_LAST) begin
            state_s = IDLE;
            addr_s  = ADDR_ZERO;
            full_s  = 1'b0;
          end else begin
            addr_s = addr_r + ADDR_ONE;
          end
        end else begin
          addr_s = addr_r;
        end
      end
      default: begin
        state_s = IDLE;
        addr_s  = ADDR_ZERO;
        full_s  = 1'b0;
      end
    endcase
  end

  assign o_ram_we   = we_s;
  assign o_ram_addr = addr_r;
  assign o_rd_valid = rd_valid_r;
  assign o_full     = full_r;
  assign o_state    = state_r;

endmodule : log_mem_ctrl

// File: tb/tb_log_mem_ctrl.sv
// Self-checking bench for log_mem_ctrl: directed scenarios plus a randomized
// tail, all compared against a count-based behavioural model of the log.
module tb_log_mem_ctrl;

  localparam int NB    = 8;
  localparam int DEPTH = 1 << NB;
  localparam int P_IDLE  = 0;
  localparam int P_WRITE = 1;
  localparam int P_FULL  = 2;
  localparam int P_READ  = 3;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_log_en = 1'b0;
  logic          i_read_en = 1'b0;
  logic          i_sample_valid = 1'b0;
  logic          o_ram_we;
  logic [NB-1:0] o_ram_addr;
  logic          o_rd_valid;
  logic          o_full;
  logic [1:0]    o_state;

  int total = 0;
  int bad   = 0;

  // Model: phase, samples logged so far, samples read so far.
  int phase  = P_IDLE;
  int logged = 0;
  int nread  = 0;
  bit m_rdv  = 1'b0;
  bit rst_drv = 1'b0;
  bit readout_done = 1'b0;
  int dut_pulses = 0;

  log_mem_ctrl #(.NB_ADDR(NB)) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_log_en      (i_log_en),
    .i_read_en     (i_read_en),
    .i_sample_valid(i_sample_valid),
    .o_ram_we      (o_ram_we),
    .o_ram_addr    (o_ram_addr),
    .o_rd_valid    (o_rd_valid),
    .o_full        (o_full),
    .o_state       (o_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase = P_IDLE;
    logged = 0;
    nread = 0;
    m_rdv = 1'b0;
    readout_done = 1'b0;
    dut_pulses = 0;
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic model_step(input bit l, input bit r, input bit v);
    bit rdv;
    rdv = 1'b0;
    if (!rst_drv) begin
      model_reset();
      return;
    end
    case (phase)
      P_IDLE: if (l) begin phase = P_WRITE; logged = 0; end
      P_WRITE: begin
        if (v) begin
          logged++;
          if (logged == DEPTH) phase = P_FULL;
          else if (!l) begin phase = P_IDLE; logged = 0; end
        end else if (!l) begin
          phase = P_IDLE;
          logged = 0;
        end
      end
      P_FULL: if (r) begin phase = P_READ; nread = 0; end
      P_READ: begin
        if (r) begin
          rdv = 1'b1;
          nread++;
          if (nread == DEPTH) begin
            phase = P_IDLE;
            readout_done = 1'b1;
          end
        end
      end
      default: phase = P_IDLE;
    endcase
    m_rdv = rdv;
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check_all(input bit v);
    int exp_addr;
    exp_addr = (phase == P_WRITE) ? logged : (phase == P_READ) ? nread : 0;
    chk("state",    32'(o_state),    32'(phase));
    chk("ram_we",   32'(o_ram_we),   32'((phase == P_WRITE) && v));
    chk("ram_addr", 32'(o_ram_addr), 32'(exp_addr));
    chk("full",     32'(o_full),     32'((phase == P_FULL) || (phase == P_READ)));
    chk("rd_valid", 32'(o_rd_valid), 32'(m_rdv));
    if (o_rd_valid) dut_pulses++;
    if (readout_done && m_rdv) begin
      chk("readout_pulses", 32'(dut_pulses), 32'(DEPTH));
      dut_pulses = 0;
      readout_done = 1'b0;
    end
  endtask

  task automatic cycle(input bit l, input bit r, input bit v);
    @(negedge clk);
    i_reset = rst_drv;
    i_log_en = l;
    i_read_en = r;
    i_sample_valid = v;
    #1;
    check_all(v);
    @(posedge clk);
    model_step(l, r, v);
  endtask

  // Drop reset between edges and confirm outputs clear without a clock.
  task automatic async_reset();
    @(negedge clk);
    #1;
    i_reset = 1'b0;
    rst_drv = 1'b0;
    model_reset();
    #1;
    chk("async_state", 32'(o_state),    32'(0));
    chk("async_we",    32'(o_ram_we),   32'(0));
    chk("async_addr",  32'(o_ram_addr), 32'(0));
    chk("async_full",  32'(o_full),     32'(0));
    chk("async_rdv",   32'(o_rd_valid), 32'(0));
    @(posedge clk);
  endtask

  task automatic bound_fail(input string tag);
    bad++;
    $error("FAIL %s: observed=timeout expected=completion", tag);
  endtask

  initial begin
    int guard;
    bit dropped;

    // Reset held low 50 ns with logging requested.
    #1 i_reset = 1'b0;
    rst_drv = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1);
    rst_drv = 1'b1;

    // Full write pass with a sample every cycle.
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b1);
    // Log is full: samples must not be written.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));

    // Read-out with random gaps plus a 5-cycle pause at address 100.
    dropped = 1'b0;
    guard = 0;
    while (phase != P_IDLE && guard < 2000) begin
      if (phase == P_READ && nread == 100 && !dropped) begin
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        dropped = 1'b1;
      end else begin
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
      end
      guard++;
    end
    if (guard >= 2000) bound_fail("readout_bound");
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);

    // Partial log of 40 samples abandoned, then a fresh complete log.
    cycle(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (logged < 40 && guard < 1000) begin
      cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      guard++;
    end
    if (guard >= 1000) bound_fail("partial_bound");
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (phase != P_FULL && guard < 3000) begin
      cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      guard++;
    end
    if (guard >= 3000) bound_fail("refill_bound");

    // Read to address 128, then reset asynchronously mid read-out.
    cycle(1'b0, 1'b1, 1'b0);
    guard = 0;
    while (nread < 128 && guard < 1000) begin
      cycle(1'b0, 1'b1, 1'b0);
      guard++;
    end
    if (guard >= 1000) bound_fail("read128_bound");
    async_reset();
    rst_drv = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));

    // Randomized tail with occasional asynchronous resets.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        async_reset();
        rst_drv = 1'b1;
      end
      cycle(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_log_mem_ctrl

// File: doc/log_mem_ctrl.md
LOG_MEM_CTRL -- requirements
Module: log_mem_ctrl

Interface
REQ-001 Parameter NB_ADDR, default 8, log-RAM address width; depth DEPTH = 2^NB_ADDR.
REQ-002 i_clock  input  1  system clock, all state updates on rising edge.
REQ-003 i_reset  input  1  one clock; reset is asynchronous and active-low.
REQ-004 i_log_en  input  1  level, requests write (logging) phase.
REQ-005 i_read_en  input  1  level, requests/continues read-out phase.
REQ-006 i_sample_valid  input  1  one-cycle strobe, datapath sample ready for logging.
REQ-007 o_ram_we  output  1  BRAM write enable, shared by both log RAMs.
REQ-008 o_ram_addr  output  NB_ADDR  BRAM address, shared for write and read.
REQ-009 o_rd_valid  output  1  BRAM read data valid this cycle.
REQ-010 o_full  output  1  log RAMs hold DEPTH unread samples.
REQ-011 o_state  output  2  current FSM state encoding, for debug.

Function
REQ-012 FSM states SHALL be IDLE=0, WRITE=1, FULL=2, READ=3.
REQ-013 IDLE: i_log_en=1 -> WRITE, address counter cleared to 0; else i_read_en ignored, stay IDLE.
REQ-014 WRITE: o_ram_we SHALL equal i_sample_valid (combinational, same cycle), write at current o_ram_addr.
REQ-015 WRITE: each cycle with o_ram_we=1 address counter increments by 1, modulo DEPTH.
REQ-016 WRITE: write at address DEPTH-1 -> FULL next cycle, counter wraps to 0.
REQ-017 WRITE: i_log_en=0 with no write that cycle -> IDLE, partial log discarded, counter cleared.
REQ-018 WRITE: i_log_en=0 in same cycle as a valid write -> write still performed, then IDLE.
REQ-019 FULL: o_full=1 (registered, asserted first cycle in FULL); o_ram_we=0; i_log_en and i_sample_valid ignored (no overwrite).
REQ-020 FULL: i_read_en=1 -> READ, counter at 0; o_full stays 1 until read-out completes.
REQ-021 READ: each cycle with i_read_en=1 counter increments; o_rd_valid=1 exactly one cycle after each such cycle (1-cycle BRAM latency).
REQ-022 READ: i_read_en=0 pauses; counter holds; o_rd_valid=0 the following cycle.
REQ-023 READ: read issued at address DEPTH-1 -> IDLE next cycle, o_full cleared same edge, counter 0; final o_rd_valid pulse still occurs in IDLE.
REQ-024 o_ram_we SHALL be 0 in every state except WRITE.
REQ-025 Exactly DEPTH o_rd_valid pulses per completed read-out, addresses 0..DEPTH-1 in order.
REQ-026 o_state SHALL reflect the registered FSM state.

Reset
REQ-027 i_reset=0 SHALL immediately force IDLE, counter 0, o_full=0, o_rd_valid=0, o_ram_we=0, o_ram_addr=0, o_state=0.
REQ-028 Reset mid-WRITE or mid-READ SHALL abandon the operation; no state retained after release.
REQ-029 First transition after release occurs on the first rising edge with i_reset=1.

Structure
REQ-030 State encodings (IDLE/WRITE/FULL/READ) and default NB_ADDR SHALL reside in the shared project constants include file used by top.
REQ-031 Single module, no sub-modules; address counter and FSM in one block; instantiated in top between generator/filter path and the two log BRAMs.

Verification
REQ-032 Reset held low 50 ns with i_log_en=1 -> o_state=0, o_ram_we=0, o_ram_addr=0 throughout; WRITE entered first edge after release.
REQ-033 NB_ADDR=8, i_log_en=1, i_sample_valid every cycle -> 256 writes at addr 0..255, o_full=1 on cycle 257, o_ram_we=0 thereafter.
REQ-034 FULL with i_sample_valid toggling and i_log_en=1 -> no o_ram_we pulse; i_read_en=1 -> 256 o_rd_valid pulses, addr 0..255, then o_state=0, o_full=0.
REQ-035 READ, drop i_read_en for 5 cycles at addr 100 -> o_ram_addr holds 100, o_rd_valid low 5 cycles, resumes at 100 with no gap or repeat.
REQ-036 WRITE, i_log_en=0 after 40 writes -> IDLE, counter 0; re-enable -> writing restarts at addr 0, o_full only after 256 further writes.
REQ-037 Assert i_reset=0 at read addr 128 -> all outputs to reset values asynchronously before next edge; later i_read_en alone keeps IDLE.
